// File: rtl/mem_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbitrated memory.
//   - Default geometry (DATA_WIDTH, MEM_DEPTH, ADDR_WIDTH, NUM_CH) and BE_WIDTH.
//   - mem_req_t: one request payload (we, addr, wdata, be), used by benches and
//     front ends that build requests.
//   - rr_distance(): how many steps channel ch sits after the priority pointer.
package mem_rr_arbiter_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int MEM_DEPTH  = 64;
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);
    localparam int NUM_CH     = 2;
    localparam int BE_WIDTH   = DATA_WIDTH / 8;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BE_WIDTH-1:0]   be;
    } mem_req_t;

    // Position of channel ch in the scan order that starts at ptr (0 = first).
    function automatic int rr_distance(input int ch, input int ptr, input int n);
        return (ch + n - ptr) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (pointer returns to 0)
//   req       - per-channel request
//   advance   - a grant was consumed this cycle; pointer moves past the winner
//   gnt       - one-hot grant, combinational from req and the pointer
module rr_arbiter
    import mem_rr_arbiter_pkg::*;
#(
    parameter int NUM_CH = mem_rr_arbiter_pkg::NUM_CH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] gnt
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] gnt_idx;
    int               best;

    // Winner is the requesting channel closest to the pointer in scan order.
    // Distances are unique, so at most one channel can match.
    always_comb begin
        best    = NUM_CH;
        gnt_idx = '0;
        gnt     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (req[i] && (rr_distance(i, int'(ptr_reg), NUM_CH) < best)) begin
                best    = rr_distance(i, int'(ptr_reg), NUM_CH);
                gnt_idx = PTR_W'(i);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            gnt[i] = (best < NUM_CH) && (PTR_W'(i) == gnt_idx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (advance) begin
            ptr_reg <= (gnt_idx == PTR_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Single-port memory shared by NUM_CH requesters through a round-robin arbiter.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   req_valid   - per-channel request valid
//   req_ready   - per-channel grant (combinational, at most one high)
//   req_we      - per-channel write(1)/read(0)
//   req_addr    - packed addresses, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata   - packed write data
//   req_be      - packed byte enables
//   rsp_valid   - one-hot response strobe, one cycle after accept
//   rsp_rdata   - read data for the responding channel (0 for writes/errors)
//   rsp_err     - response address was >= MEM_DEPTH
module mem_rr_arbiter
    import mem_rr_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = mem_rr_arbiter_pkg::DATA_WIDTH,
    parameter int MEM_DEPTH  = mem_rr_arbiter_pkg::MEM_DEPTH,
    parameter int NUM_CH     = mem_rr_arbiter_pkg::NUM_CH,
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH),
    localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            req_valid,
    output logic [NUM_CH-1:0]            req_ready,
    input  logic [NUM_CH-1:0]            req_we,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_CH*BE_WIDTH-1:0]   req_be,
    output logic [NUM_CH-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]        rsp_rdata,
    output logic                         rsp_err
);

    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    logic [NUM_CH-1:0] gnt;
    logic              accept;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (accept),
        .gnt     (gnt)
    );

    // The arbiter only grants requesting channels, so any grant is a transfer.
    assign req_ready = gnt;
    assign accept    = |gnt;

    // Unpack the per-channel payloads.
    logic [ADDR_WIDTH-1:0] ch_addr  [NUM_CH];
    logic [DATA_WIDTH-1:0] ch_wdata [NUM_CH];
    logic [BE_WIDTH-1:0]   ch_be    [NUM_CH];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
        assign ch_addr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign ch_wdata[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        assign ch_be[gi]    = req_be[gi*BE_WIDTH +: BE_WIDTH];
    end

    // One-hot AND-OR mux of the granted channel's payload.
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [BE_WIDTH-1:0]   sel_be;

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) begin
                sel_we    = sel_we | req_we[i];
                sel_addr  = sel_addr | ch_addr[i];
                sel_wdata = sel_wdata | ch_wdata[i];
                sel_be    = sel_be | ch_be[i];
            end
        end
    end

    // Only reachable with a non-power-of-two depth.
    logic in_range;
    assign in_range = ({1'b0, sel_addr} < DEPTH_LIMIT);

    // Storage: no reset so it maps onto block RAM with a registered read port.
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rd_word_reg;

    always_ff @(posedge clk) begin
        if (accept && in_range) begin
            if (sel_we) begin
                for (int b = 0; b < BE_WIDTH; b++) begin
                    if (sel_be[b]) begin
                        mem[sel_addr][b*8 +: 8] <= sel_wdata[b*8 +: 8];
                    end
                end
            end else begin
                rd_word_reg <= mem[sel_addr];
            end
        end
    end

    // Response qualifiers; rd_sel_reg forces rsp_rdata to 0 except on a good read.
    logic [NUM_CH-1:0] rsp_valid_reg;
    logic              rsp_err_reg;
    logic              rd_sel_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_reg <= '0;
            rsp_err_reg   <= 1'b0;
            rd_sel_reg    <= 1'b0;
        end else begin
            rsp_valid_reg <= gnt;
            rsp_err_reg   <= accept && !in_range;
            rd_sel_reg    <= accept && !sel_we && in_range;
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_rdata = rd_sel_reg ? rd_word_reg : '0;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
module tb_mem_rr_arbiter;

    logic clk;
    logic rst;

    // Default instance: 2 channels, 64 words
    logic [1:0]  v, we, rdy, rv;
    logic [11:0] a;
    logic [63:0] wd;
    logic [7:0]  be;
    logic [31:0] rd;
    logic        err;

    // Non-power-of-two instance: 2 channels, 48 words
    logic [1:0]  v48, we48, rdy48, rv48;
    logic [11:0] a48;
    logic [63:0] wd48;
    logic [7:0]  be48;
    logic [31:0] rd48;
    logic        err48;

    int n_checks = 0;
    int n_errors = 0;

    mem_rr_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(v), .req_ready(rdy), .req_we(we), .req_addr(a),
        .req_wdata(wd), .req_be(be),
        .rsp_valid(rv), .rsp_rdata(rd), .rsp_err(err)
    );

    mem_rr_arbiter #(.MEM_DEPTH(48)) dut48 (
        .clk(clk), .rst(rst),
        .req_valid(v48), .req_ready(rdy48), .req_we(we48), .req_addr(a48),
        .req_wdata(wd48), .req_be(be48),
        .rsp_valid(rv48), .rsp_rdata(rd48), .rsp_err(err48)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1. Presents one request, checks the grant, waits for the
    // accept edge, drops valid and checks the response one cycle later.
    task automatic txn(input bit d48, input int ch, input bit w, input logic [5:0] addr,
                       input logic [31:0] data, input logic [3:0] bemask,
                       input logic [31:0] exp_rd, input bit exp_err, input string tag);
        logic [1:0] onehot;
        onehot = 2'b01 << ch;
        if (d48) begin
            v48[ch] = 1'b1; we48[ch] = w; a48[ch*6 +: 6] = addr;
            wd48[ch*32 +: 32] = data; be48[ch*4 +: 4] = bemask;
        end else begin
            v[ch] = 1'b1; we[ch] = w; a[ch*6 +: 6] = addr;
            wd[ch*32 +: 32] = data; be[ch*4 +: 4] = bemask;
        end
        #1;
        check_val({tag, ".ready"}, 64'(d48 ? rdy48 : rdy), 64'(onehot));
        @(posedge clk); #1;
        if (d48) v48[ch] = 1'b0; else v[ch] = 1'b0;
        check_val({tag, ".rsp_valid"}, 64'(d48 ? rv48 : rv), 64'(onehot));
        check_val({tag, ".rdata"}, 64'(d48 ? rd48 : rd), 64'(exp_rd));
        check_val({tag, ".err"}, 64'(d48 ? err48 : err), 64'(exp_err));
        $display("txn %-10s ch%0d %s addr=%0d wdata=%h be=%h -> rdata=%h err=%0d",
                 tag, ch, w ? "WR" : "RD", addr, data, bemask,
                 d48 ? rd48 : rd, d48 ? err48 : err);
    endtask

    initial begin
        rst = 1'b1;
        v = '0; we = '0; a = '0; wd = '0; be = '0;
        v48 = '0; we48 = '0; a48 = '0; wd48 = '0; be48 = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("reset.rsp_valid", 64'(rv), 64'h0);
        check_val("reset.rdata", 64'(rd), 64'h0);
        check_val("reset.err", 64'(err), 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single write / read
        txn(0, 0, 1, 6'd5, 32'hDEADBEEF, 4'hF, 32'h0, 0, "wr5");
        txn(0, 0, 0, 6'd5, 32'h0, 4'h0, 32'hDEADBEEF, 0, "rd5");

        // Byte enables, then a be=0 no-op write
        txn(0, 0, 1, 6'd7, 32'h11223344, 4'hF, 32'h0, 0, "wr7_full");
        txn(0, 0, 1, 6'd7, 32'hAABBCCDD, 4'h5, 32'h0, 0, "wr7_be5");
        txn(0, 0, 0, 6'd7, 32'h0, 4'h0, 32'h11BB33DD, 0, "rd7");
        txn(0, 1, 1, 6'd7, 32'hFFFFFFFF, 4'h0, 32'h0, 0, "wr7_be0");
        txn(0, 1, 0, 6'd7, 32'h0, 4'h0, 32'h11BB33DD, 0, "rd7_again");

        // Read-after-write on back-to-back accepts, top address
        txn(0, 1, 1, 6'd63, 32'h12345678, 4'hF, 32'h0, 0, "wr63");
        txn(0, 1, 0, 6'd63, 32'h0, 4'h0, 32'h12345678, 0, "raw63");

        @(posedge clk); #1;
        check_val("idle.rsp_valid", 64'(rv), 64'h0);
        check_val("idle.rdata", 64'(rd), 64'h0);

        // Contention from reset: grants 0,1,0,1
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        v = 2'b11; we = 2'b00; a = {6'd63, 6'd5};
        for (int k = 0; k < 4; k++) begin
            logic [1:0] exp_g;
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            check_val($sformatf("cont%0d.ready", k), 64'(rdy), 64'(exp_g));
            @(posedge clk); #1;
            check_val($sformatf("cont%0d.rsp_valid", k), 64'(rv), 64'(exp_g));
            check_val($sformatf("cont%0d.rdata", k), 64'(rd),
                      (k % 2 == 0) ? 64'hDEADBEEF : 64'h12345678);
            $display("txn cont%0d grant=%b rsp_valid=%b rdata=%h", k, rdy, rv, rd);
        end
        v = 2'b00;

        // Reset one cycle after a read accept; pointer was left at 1
        txn(0, 0, 0, 6'd5, 32'h0, 4'h0, 32'hDEADBEEF, 0, "pre_rst");
        rst = 1'b1;
        #1;
        check_val("midrst.rsp_valid", 64'(rv), 64'h0);
        check_val("midrst.rdata", 64'(rd), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        v = 2'b11; we = 2'b00; a = {6'd63, 6'd5};
        #1;
        check_val("post_rst.ready", 64'(rdy), 64'h1);
        @(posedge clk); #1;
        check_val("post_rst.rsp_valid", 64'(rv), 64'h1);
        check_val("post_rst.rdata", 64'(rd), 64'hDEADBEEF);
        $display("txn post_rst grant=ch0 rsp_valid=%b rdata=%h", rv, rd);
        v = 2'b00;
        @(posedge clk); #1;

        // Out-of-range on the 48-word instance
        txn(1, 0, 1, 6'd47, 32'hCAFEF00D, 4'hF, 32'h0, 0, "d48_wr47");
        txn(1, 0, 1, 6'd50, 32'hFFFFFFFF, 4'hF, 32'h0, 1, "d48_wr50");
        txn(1, 0, 0, 6'd50, 32'h0, 4'h0, 32'h0, 1, "d48_rd50");
        txn(1, 0, 0, 6'd47, 32'h0, 4'h0, 32'hCAFEF00D, 0, "d48_rd47");

        @(posedge clk); #1;
        check_val("d48_idle.err", 64'(err48), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
